// File: rtl/fft_pkg.sv
// Shared FFT helpers: ceil-log2 and index bit reversal, used by every FFT stage.
// Latency: n/a (package of pure functions).
// Backpressure: n/a.
package fft_pkg;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Reverse the low nbits of value; upper result bits are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int nbits);
    logic [31:0] r;
    logic [31:0] v;
    r = '0;
    v = value;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) begin
        r = {r[30:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream bundle between the butterfly core, the reorder stage and its consumer.
// Latency: n/a (wires only).
// Backpressure: out_hold from the consumer pauses emission; the input side has no ready.
// Ports: in_nd/in_data (input stream), out_hold (consumer pause),
//        out_nd/out_data/out_read (output stream), error (sticky overflow).
interface fft_bitrev_reorder_if #(
  parameter int WIDTH = 32
);
  logic             in_nd;
  logic [WIDTH-1:0] in_data;
  logic             out_hold;
  logic             out_nd;
  logic [WIDTH-1:0] out_data;
  logic             out_read;
  logic             error;

  // master: the environment driving samples in and consuming them out
  modport master (
    output in_nd, in_data, out_hold,
    input  out_nd, out_data, out_read, error
  );

  // slave: the reorder stage itself
  modport slave (
    input  in_nd, in_data, out_hold,
    output out_nd, out_data, out_read, error
  );
endinterface

// File: rtl/fft_reorder_ram.sv
// Ping-pong sample store: DEPTH x WIDTH, one write port, one synchronous read port.
// Latency: read data appears on rd_data one cycle after rd_en; it is the stage output register.
// Backpressure: none; rd_data holds its value while rd_en is low.
// Ports: clk, rst_n (sync, active-low, clears rd_data only), wr_en/wr_addr/wr_data,
//        rd_en/rd_addr, rd_data.
module fft_reorder_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_d;
  logic [WIDTH-1:0] rd_data_q;

  // Storage array has no reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// FFT output reorder: bit-reversed N-point frames in, natural-order frames out, ping-pong banks.
// Latency: first output 2 cycles after the edge capturing a frame's last sample; N cycles per frame.
// Backpressure: out_hold pauses the drain; input has no ready, so writes into a full bank drop and set sticky error.
// Ports: clk, rst_n (sync, active-low), bus (slave modport: in_nd/in_data, out_hold,
//        out_nd/out_data/out_read, error).
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N     = 8,
  parameter int WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  fft_bitrev_reorder_if.slave bus
);

  localparam int LOG_N = clog2(N);
  localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(N - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic             wsel_d, wsel_q;
  logic [LOG_N-1:0] wcnt_d, wcnt_q;
  logic             rsel_d, rsel_q;
  logic [LOG_N-1:0] rcnt_d, rcnt_q;
  logic [1:0]       bank_full_d, bank_full_q;
  logic [0:0]       state_d, state_q;
  logic             out_nd_d, out_nd_q;
  logic             error_d, error_q;

  logic             drain_fire;
  logic             drain_done;
  logic [1:0]       full_eff;
  logic             wr_en;
  logic [LOG_N:0]   wr_addr;
  logic [LOG_N:0]   rd_addr;
  logic [WIDTH-1:0] rd_data;

  always_comb begin
    drain_fire = (state_q == ST_DRAIN) && !bus.out_hold;
    drain_done = drain_fire && (rcnt_q == LAST_IDX);

    // A bank whose drain finishes on this edge is already free for the writer,
    // which is what lets continuous input run without drops.
    full_eff = bank_full_q;
    if (drain_done) full_eff[rsel_q] = 1'b0;

    wr_en   = bus.in_nd && !full_eff[wsel_q];
    wr_addr = {wsel_q, LOG_N'(bitrev(32'(wcnt_q), LOG_N))};
    rd_addr = {rsel_q, rcnt_q};

    // Write side
    wsel_d      = wsel_q;
    wcnt_d      = wcnt_q;
    bank_full_d = full_eff;
    if (wr_en) begin
      if (wcnt_q == LAST_IDX) begin
        wcnt_d              = '0;
        bank_full_d[wsel_q] = 1'b1;
        wsel_d              = ~wsel_q;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end
    error_d = error_q || (bus.in_nd && full_eff[wsel_q]);

    // Read side
    state_d = state_q;
    rsel_d  = rsel_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bank_full_q[rsel_q]) begin
          state_d = ST_DRAIN;
          rcnt_d  = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          rcnt_d = '0;
          rsel_d = ~rsel_q;
          // Look at the post-edge flag so a bank completing on this same edge
          // is drained without an idle bubble.
          state_d = bank_full_d[~rsel_q] ? ST_DRAIN : ST_IDLE;
        end else if (drain_fire) begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    out_nd_d = drain_fire;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wsel_q      <= 1'b0;
      wcnt_q      <= '0;
      rsel_q      <= 1'b0;
      rcnt_q      <= '0;
      bank_full_q <= 2'b00;
      state_q     <= ST_IDLE;
      out_nd_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      wsel_q      <= wsel_d;
      wcnt_q      <= wcnt_d;
      rsel_q      <= rsel_d;
      rcnt_q      <= rcnt_d;
      bank_full_q <= bank_full_d;
      state_q     <= state_d;
      out_nd_q    <= out_nd_d;
      error_q     <= error_d;
    end
  end

  fft_reorder_ram #(
    .DEPTH (2 * N),
    .AW    (LOG_N + 1),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (bus.in_data),
    .rd_en   (drain_fire),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign bus.out_nd   = out_nd_q;
  assign bus.out_read = out_nd_q;
  assign bus.out_data = rd_data;
  assign bus.error    = error_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder: random frames against a natural-order reference model.
// Latency: n/a.
// Backpressure: exercises out_hold stalls and overflow drops.
module tb_fft_bitrev_reorder;

  localparam int N     = 8;
  localparam int LOG_N = 3;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_bitrev_reorder_if #(.WIDTH(WIDTH)) bus ();

  fft_bitrev_reorder #(.N(N), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int rd_mis = 0;
  bit hold_toggle = 1'b0;

  logic [WIDTH-1:0] out_q[$];
  int               out_cyc_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] frame[N];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: collects every emitted sample and its cycle stamp.
  always @(negedge clk) begin
    if (bus.out_read !== bus.out_nd) rd_mis++;
    if (bus.out_read === 1'b1) rd_cnt++;
    if (bus.out_nd === 1'b1) begin
      out_q.push_back(bus.out_data);
      out_cyc_q.push_back(cyc);
    end
  end

  // Reference: k-th arriving sample belongs at natural index bitrev(k).
  function automatic int bitrev_ref(input int k);
    int r = 0;
    int v = k;
    for (int b = 0; b < LOG_N; b++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  task automatic model_frame();
    logic [WIDTH-1:0] nat[N];
    for (int k = 0; k < N; k++) nat[bitrev_ref(k)] = frame[k];
    for (int i = 0; i < N; i++) exp_q.push_back(nat[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (hold_toggle) bus.out_hold = ~bus.out_hold;
  endtask

  task automatic drive_sample(input logic [WIDTH-1:0] d, input int gap);
    bus.in_nd   = 1'b1;
    bus.in_data = d;
    tick();
    bus.in_nd = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_rand_frame(input int gap);
    for (int k = 0; k < N; k++) begin
      frame[k] = $urandom;
      drive_sample(frame[k], gap);
    end
    model_frame();
  endtask

  task automatic clear_obs();
    out_q.delete();
    out_cyc_q.delete();
    exp_q.delete();
    rd_cnt = 0;
    rd_mis = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_nd = 1'b0;
    bus.out_hold = 1'b0;
    hold_toggle = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    clear_obs();
  endtask

  task automatic wait_outputs(input int n, input int budget);
    int b = 0;
    while (out_q.size() < n && b < budget) begin
      tick();
      b++;
    end
    repeat (6) tick();
  endtask

  task automatic test_reset();
    bus.in_nd = 1'b0;
    bus.in_data = '0;
    bus.out_hold = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (bus.out_nd !== 1'b0) begin errors++; $display("FAIL reset_out_nd got %b want 0", bus.out_nd); end
    checks++; if (bus.out_read !== 1'b0) begin errors++; $display("FAIL reset_out_read got %b want 0", bus.out_read); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", bus.error); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
    rst_n = 1'b1;
    clear_obs();
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] want[N];
    int last_edge;
    want = '{32'd0, 32'd4, 32'd2, 32'd6, 32'd1, 32'd5, 32'd3, 32'd7};
    do_reset();
    for (int k = 0; k < N; k++) drive_sample(WIDTH'(k), 0);
    last_edge = cyc;
    wait_outputs(N, 40);
    checks++; if (out_q.size() != N) begin errors++; $display("FAIL single_count got %0d want %0d", out_q.size(), N); end
    for (int i = 0; i < N && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== want[i]) begin errors++; $display("FAIL single_order idx %0d got %0d want %0d", i, out_q[i], want[i]); end
    end
    if (out_cyc_q.size() > 0) begin
      checks++; if (out_cyc_q[0] !== last_edge + 2) begin errors++; $display("FAIL single_latency got cycle %0d want %0d", out_cyc_q[0], last_edge + 2); end
    end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL single_error got %b want 0", bus.error); end
  endtask

  task automatic test_back_to_back();
    int gaps = 0;
    do_reset();
    for (int f = 0; f < 3; f++) send_rand_frame(0);
    wait_outputs(3 * N, 60);
    checks++; if (out_q.size() != 3 * N) begin errors++; $display("FAIL b2b_count got %0d want %0d", out_q.size(), 3 * N); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_data idx %0d got %h want %h", i, out_q[i], exp_q[i]); end
    end
    for (int i = 1; i < out_cyc_q.size(); i++) if (out_cyc_q[i] != out_cyc_q[0] + i) gaps++;
    checks++; if (gaps !== 0) begin errors++; $display("FAIL b2b_contiguous got %0d gaps want 0", gaps); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL b2b_error got %b want 0", bus.error); end
  endtask

  task automatic test_overflow();
    do_reset();
    send_rand_frame(0);
    bus.out_hold = 1'b1;
    send_rand_frame(0);
    // frame 3 starts while both banks are occupied: every one of these is dropped
    for (int k = 0; k < 4; k++) drive_sample($urandom, 0);
    repeat (8) tick();
    checks++; if (out_q.size() != 0) begin errors++; $display("FAIL ovf_hold_emits got %0d want 0", out_q.size()); end
    checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL ovf_error got %b want 1", bus.error); end
    bus.out_hold = 1'b0;
    wait_outputs(2 * N, 60);
    checks++; if (out_q.size() != 2 * N) begin errors++; $display("FAIL ovf_count got %0d want %0d", out_q.size(), 2 * N); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_data idx %0d got %h want %h", i, out_q[i], exp_q[i]); end
    end
    checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", bus.error); end
  endtask

  task automatic test_hold_toggle();
    do_reset();
    hold_toggle = 1'b1;
    for (int f = 0; f < 2; f++) send_rand_frame(0);
    wait_outputs(2 * N, 80);
    hold_toggle = 1'b0;
    bus.out_hold = 1'b0;
    repeat (4) tick();
    checks++; if (rd_cnt != 2 * N) begin errors++; $display("FAIL toggle_read_count got %0d want %0d", rd_cnt, 2 * N); end
    checks++; if (out_q.size() != 2 * N) begin errors++; $display("FAIL toggle_count got %0d want %0d", out_q.size(), 2 * N); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL toggle_data idx %0d got %h want %h", i, out_q[i], exp_q[i]); end
    end
    checks++; if (rd_mis !== 0) begin errors++; $display("FAIL toggle_read_vs_nd got %0d mismatches want 0", rd_mis); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL toggle_error got %b want 0", bus.error); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int k = 0; k < 5; k++) drive_sample($urandom, 0);
    rst_n = 1'b0;
    tick();
    checks++; if (bus.out_nd !== 1'b0) begin errors++; $display("FAIL midrst_out_nd got %b want 0", bus.out_nd); end
    rst_n = 1'b1;
    clear_obs();
    send_rand_frame(0);
    wait_outputs(N, 40);
    checks++; if (out_q.size() != N) begin errors++; $display("FAIL midrst_count got %0d want %0d", out_q.size(), N); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_data idx %0d got %h want %h", i, out_q[i], exp_q[i]); end
    end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL midrst_error got %b want 0", bus.error); end
  endtask

  task automatic test_sparse();
    int gaps = 0;
    do_reset();
    for (int f = 0; f < 2; f++) send_rand_frame(2);
    wait_outputs(2 * N, 60);
    checks++; if (out_q.size() != 2 * N) begin errors++; $display("FAIL sparse_count got %0d want %0d", out_q.size(), 2 * N); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL sparse_data idx %0d got %h want %h", i, out_q[i], exp_q[i]); end
    end
    for (int i = 0; i < out_cyc_q.size(); i++) begin
      if (out_cyc_q[i] != out_cyc_q[(i / N) * N] + (i % N)) gaps++;
    end
    checks++; if (gaps !== 0) begin errors++; $display("FAIL sparse_contiguous got %0d gaps want 0", gaps); end
    checks++; if (rd_mis !== 0) begin errors++; $display("FAIL sparse_read_vs_nd got %0d mismatches want 0", rd_mis); end
  endtask

  initial begin
    bus.in_nd = 1'b0;
    bus.in_data = '0;
    bus.out_hold = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_hold_toggle();
    test_reset_midframe();
    test_sparse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
